// File: rtl/hdr_emitter.sv
// rtl/hdr_emitter.sv - pops parsed headers from the output latch and streams them as beats
// Optional feature macro: HDR_EMIT_B2B_EN (pop the next header on the last-beat transfer)
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 20
`endif
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif

module hdr_emitter #(
  parameter int HDR_LEN    = `HDR_MAX_LEN,
  parameter int NUM_PORTS  = `NUM_PORTS,
  parameter int BEAT_BYTES = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                empty_i,
  input  logic [HDR_LEN-1:0][`BYTE_BUS-1:0]   pkt_hdr_i,
  input  logic [NUM_PORTS-1:0]                out_port_i,
  output logic                                rd_o,
  output logic [8*BEAT_BYTES-1:0]             data_o,
  output logic [BEAT_BYTES-1:0]               keep_o,
  output logic [NUM_PORTS-1:0]                port_o,
  output logic                                sop_o,
  output logic                                eop_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [31:0]                         pkt_cnt_o
);

  localparam int NBEATS     = (HDR_LEN + BEAT_BYTES - 1) / BEAT_BYTES;
  localparam int IDX_W      = $clog2(NBEATS);
  localparam int BEAT_W     = 8 * BEAT_BYTES;
  localparam int LAST_LANES = HDR_LEN - (NBEATS - 1) * BEAT_BYTES;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NBEATS - 1);
  localparam logic [BEAT_BYTES-1:0] LAST_KEEP = {BEAT_BYTES{1'b1}} >> (BEAT_BYTES - LAST_LANES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q;
  logic [HDR_LEN-1:0][`BYTE_BUS-1:0]  shadow_q;
  logic [NBEATS-1:0][BEAT_W-1:0]      beats;
  logic                               pop, send, xfer, last_xfer;

  assign send      = (state_q == SEND);
  assign xfer      = send && ready_i;
  assign last_xfer = xfer && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_i) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
`ifdef HDR_EMIT_B2B_EN
          if (!empty_i) pop = 1'b1;
          else          state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The FSM sits in IDLE during reset, so the pop strobe must be gated explicitly.
  assign rd_o = pop & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      port_o    <= '0;
      pkt_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        shadow_q <= pkt_hdr_i;
        port_o   <= out_port_i;
        idx_q    <= '0;
      end else if (last_xfer) begin
        idx_q <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + 1'b1;
      end
      if (last_xfer) pkt_cnt_o <= pkt_cnt_o + 32'd1;
    end
  end

  // Zero-extending the shadow pads the tail lanes of the last beat with zeros.
  assign beats   = (NBEATS * BEAT_W)'(shadow_q);
  assign valid_o = send;
  assign data_o  = send ? beats[idx_q] : '0;
  assign keep_o  = !send ? '0 : ((idx_q == LAST_IDX) ? LAST_KEEP : {BEAT_BYTES{1'b1}});
  assign sop_o   = send && (idx_q == '0);
  assign eop_o   = send && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_hdr_emitter.sv
// tb/tb_hdr_emitter.sv - directed bench for hdr_emitter with HDR_LEN=20, BEAT_BYTES=8, NUM_PORTS=4
module tb_hdr_emitter;

  logic              clk = 1'b0;
  logic              rst;
  logic              empty_i;
  logic [19:0][7:0]  pkt_hdr_i;
  logic [3:0]        out_port_i;
  logic              rd_o;
  logic [63:0]       data_o;
  logic [7:0]        keep_o;
  logic [3:0]        port_o;
  logic              sop_o, eop_o, valid_o;
  logic              ready_i;
  logic [31:0]       pkt_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q_base[$];
  logic [3:0] q_port[$];

  always #5 clk = ~clk;

  hdr_emitter #(.HDR_LEN(20), .NUM_PORTS(4), .BEAT_BYTES(8)) dut (
    .clk(clk), .rst(rst), .empty_i(empty_i), .pkt_hdr_i(pkt_hdr_i),
    .out_port_i(out_port_i), .rd_o(rd_o), .data_o(data_o), .keep_o(keep_o),
    .port_o(port_o), .sop_o(sop_o), .eop_o(eop_o), .valid_o(valid_o),
    .ready_i(ready_i), .pkt_cnt_o(pkt_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [7:0] b, input int k);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++)
      if (k * 8 + j < 20) r[8*j +: 8] = b + 8'(k * 8 + j);
    return r;
  endfunction

  task automatic present(input logic [7:0] b, input logic [3:0] p);
    for (int i = 0; i < 20; i++) pkt_hdr_i[i] = b + 8'(i);
    out_port_i = p;
    empty_i    = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic [3:0] p);
    if (empty_i) present(b, p);
    else begin
      q_base.push_back(b);
      q_port.push_back(p);
    end
  endtask

  // Advances one clock and emulates the latch: a pop loads the next queued header or empties it.
  task automatic tick();
    logic pop_now;
    #1;
    pop_now = rd_o;
    @(posedge clk);
    #1;
    if (pop_now) begin
      if (q_base.size() > 0) present(q_base.pop_front(), q_port.pop_front());
      else empty_i = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int nv, n_eop, n_rd, n_val;
    logic [7:0]  vseq, rseq;
    logic [63:0] bdata;

    rst = 1'b0; empty_i = 1'b1; ready_i = 1'b1; pkt_hdr_i = '0; out_port_i = '0;
    #2;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_sop", 64'(sop_o), 64'd0);
    chk("rst_eop", 64'(eop_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_keep", 64'(keep_o), 64'd0);
    chk("rst_port", 64'(port_o), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt_o), 64'd0);
    empty_i = 1'b0;
    #1;
    chk("rst_rd_gated", 64'(rd_o), 64'd0);
    empty_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_valid", 64'(valid_o), 64'd0);

    // Single packet hdr[i]=i, port 0010
    push(8'h00, 4'b0010);
    #1;
    chk("t1_rd_pulse", 64'(rd_o), 64'd1);
    tick();
    chk("t1_rd_off", 64'(rd_o), 64'd0);
    chk("t1_b0_valid", 64'(valid_o), 64'd1);
    chk("t1_b0_sop", 64'(sop_o), 64'd1);
    chk("t1_b0_eop", 64'(eop_o), 64'd0);
    chk("t1_b0_data", data_o, 64'h0706050403020100);
    chk("t1_b0_keep", 64'(keep_o), 64'hFF);
    chk("t1_port", 64'(port_o), 64'b0010);
    tick();
    chk("t1_b1_data", data_o, 64'h0F0E0D0C0B0A0908);
    chk("t1_b1_keep", 64'(keep_o), 64'hFF);
    chk("t1_b1_sopeop", 64'({sop_o, eop_o}), 64'b00);
    tick();
    chk("t1_b2_data", data_o, 64'h0000000013121110);
    chk("t1_b2_keep", 64'(keep_o), 64'h0F);
    chk("t1_b2_sopeop", 64'({sop_o, eop_o}), 64'b01);
    tick();
    chk("t1_after_valid", 64'(valid_o), 64'd0);
    chk("t1_after_data", data_o, 64'd0);
    chk("t1_after_keep", 64'(keep_o), 64'd0);
    chk("t1_after_port_hold", 64'(port_o), 64'b0010);
    chk("t1_cnt", 64'(pkt_cnt_o), 64'd1);

    // Backpressure: ready low for 5 cycles while beat 1 is presented
    push(8'h40, 4'b0100);
    nv = 0;
    tick(); nv += int'(valid_o);
    chk("t2_b0_sop", 64'(sop_o), 64'd1);
    tick(); nv += int'(valid_o);
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); nv += int'(valid_o);
      chk("t2_hold_data", data_o, beat(8'h40, 1));
      chk("t2_hold_flags", 64'({valid_o, sop_o, eop_o, keep_o}), 64'b1_0_0_11111111);
    end
    ready_i = 1'b1;
    tick(); nv += int'(valid_o);
    chk("t2_b2_data", data_o, beat(8'h40, 2));
    chk("t2_b2_eop", 64'(eop_o), 64'd1);
    tick(); nv += int'(valid_o);
    chk("t2_valid_cycles", 64'(nv), 64'd8);
    chk("t2_cnt", 64'(pkt_cnt_o), 64'd2);

    // Two packets queued
    push(8'h80, 4'b0001);
    push(8'hA0, 4'b1000);
    vseq = '0; rseq = '0; bdata = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      vseq[i] = valid_o;
      rseq[i] = rd_o;
      if (sop_o && i > 0) bdata = data_o;
    end
`ifdef HDR_EMIT_B2B_EN
    chk("t3_valid_seq", 64'(vseq), 64'b0011_1111);
    chk("t3_rd_seq", 64'(rseq), 64'b0000_0100);
`else
    chk("t3_valid_seq", 64'(vseq), 64'b0111_0111);
    chk("t3_rd_seq", 64'(rseq), 64'b0000_1000);
`endif
    chk("t3_pkt2_b0", bdata, beat(8'hA0, 0));
    chk("t3_pkt2_port", 64'(port_o), 64'b1000);
    chk("t3_cnt", 64'(pkt_cnt_o), 64'd4);

    // Reset during beat 1
    push(8'h10, 4'b0011);
    tick();
    tick();
    chk("t4_pre_beat1", data_o, beat(8'h10, 1));
    rst = 1'b0;
    #1;
    chk("t4_rst_outs", 64'({valid_o, sop_o, eop_o, rd_o, keep_o, port_o}), 64'd0);
    chk("t4_rst_data", data_o, 64'd0);
    chk("t4_rst_cnt", 64'(pkt_cnt_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_eop = 0; n_val = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_eop += int'(eop_o);
      n_val += int'(valid_o);
    end
    chk("t4_no_eop", 64'(n_eop), 64'd0);
    chk("t4_no_valid", 64'(n_val), 64'd0);
    chk("t4_cnt_zero", 64'(pkt_cnt_o), 64'd0);
    push(8'h30, 4'b0101);
    tick();
    chk("t4_next_sop", 64'(sop_o), 64'd1);
    chk("t4_next_data", data_o, beat(8'h30, 0));
    tick(); tick(); tick();
    chk("t4_next_cnt", 64'(pkt_cnt_o), 64'd1);

    // Counter wrap
    force dut.pkt_cnt_o = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_o;
    #1;
    chk("t5_preload", 64'(pkt_cnt_o), 64'hFFFF_FFFF);
    push(8'h50, 4'b1111);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_wrap", 64'(pkt_cnt_o), 64'd0);

    // Empty latch for 100 cycles
    n_rd = 0; n_val = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_rd  += int'(rd_o);
      n_val += int'(valid_o);
    end
    chk("t6_no_rd", 64'(n_rd), 64'd0);
    chk("t6_no_valid", 64'(n_val), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hdr_emitter.md
# hdr_emitter

Downstream consumer of the processor-output header latch. Pops one parsed header (`HDR_LEN` bytes plus egress port mask) from the latch when it is non-empty. Streams the header as `BEAT_BYTES`-wide beats on a valid/ready interface toward the egress deparser/merge stage. Holds a private shadow copy, so the latch is freed on the pop cycle and can refill while the emitter is sending.

## Interface
Parameters:
- `HDR_LEN`, default `` `HDR_MAX_LEN ``: header bytes per packet; always the full header is emitted.
- `NUM_PORTS`, default `` `NUM_PORTS ``: width of egress port mask.
- `BEAT_BYTES`, default 8: bytes per output beat; `NBEATS = ceil(HDR_LEN/BEAT_BYTES)`, must be ≥2.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `empty_i`  in  1  latch empty flag.
- `pkt_hdr_i`  in  `` `BYTE_BUS `` × `HDR_LEN`  latch header bytes, index 0 first on wire.
- `out_port_i`  in  `NUM_PORTS`  latch egress mask.
- `rd_o`  out  1  pop strobe to latch, combinational.
- `data_o`  out  8·`BEAT_BYTES`  beat data, lane j = bits [8j+7:8j].
- `keep_o`  out  `BEAT_BYTES`  lane-valid mask.
- `port_o`  out  `NUM_PORTS`  egress mask of current packet, stable for whole packet.
- `sop_o` / `eop_o`  out  1  first / last beat of packet.
- `valid_o`  out  1  beat valid.
- `ready_i`  in  1  downstream accepts beat.
- `pkt_cnt_o`  out  32  packets fully emitted, wraps modulo 2^32.

## Operation
- FSM states: IDLE, SEND.
- IDLE: `rd_o = !empty_i`. On the same edge: capture `pkt_hdr_i` and `out_port_i` into shadow, set `idx <= 0`, go to SEND. The latch clears at that same edge.
- SEND: `valid_o = 1`. Beat `k = idx`; lane j carries `shadow[k·BEAT_BYTES + j]`. Lanes beyond `HDR_LEN` are driven 0 and have keep bit 0.
- `keep_o` is all-ones except on the last beat: low `HDR_LEN − (NBEATS−1)·BEAT_BYTES` bits set.
- `sop_o = (idx == 0)`; `eop_o = (idx == NBEATS−1)`; both qualified by `valid_o`.
- Transfer = `valid_o && ready_i`. Non-last transfer: `idx++`. Last transfer: `pkt_cnt_o++`, then the next state depends on configuration.
- `valid_o` deasserted → `data_o`, `keep_o`, `sop_o`, `eop_o` = 0. `port_o` holds its last value.
- `rd_o` never asserts in SEND except as allowed under Configuration.
- Reset values, all immediate on `rst` low: state IDLE, `idx` 0, shadow 0, `port_o` 0, `pkt_cnt_o` 0, `valid_o`/`sop_o`/`eop_o` 0, `data_o`/`keep_o` 0.
- `rd_o` is 0 while `rst` is low.

## Timing
- Latch-pop to first beat valid: 1 cycle. Pop edge → SEND, `valid_o` high in the next cycle.
- Throughput: one beat per cycle while `ready_i` is high.
- Backpressure: when `ready_i` is low, all beat outputs hold stable. `ready_i` may toggle arbitrarily; `valid_o` never drops mid-packet.
- Simultaneous events: latch refill during SEND is ignored until the rules below allow a pop. `empty_i` falling in the same cycle the FSM enters IDLE is popped in that IDLE cycle.
- Reset mid-packet: the packet is discarded; no `eop_o` is emitted; `pkt_cnt_o` is not incremented. The latch's next header is popped normally after release.

## Configuration
- `HDR_EMIT_B2B_EN` defined: on the last-beat transfer, `rd_o = !empty_i` in the same cycle.
  - If asserted: capture the new header, `idx <= 0`, stay in SEND. Back-to-back packets have no idle cycle, giving `NBEATS` cycles per packet.
  - If not asserted: go to IDLE.
- Undefined: the last-beat transfer always goes to IDLE, so there is at least one bubble and `NBEATS+1` cycles per packet. `rd_o` is only ever asserted in IDLE.

## Test plan
All tests use `HDR_LEN`=20, `BEAT_BYTES`=8, `NUM_PORTS`=4, so `NBEATS`=3.
- Single packet, hdr[i]=i, port=4'b0010, `ready_i`=1:
  - `rd_o` pulses 1 cycle.
  - Beats `data_o` = 0x0706050403020100, then 0x0F0E0D0C0B0A0908, then 0x0000000013121110.
  - `keep_o` = FF, FF, 0F; `sop_o` on beat 0, `eop_o` on beat 2; `port_o`=0010; `pkt_cnt_o`=1.
- Backpressure: `ready_i` low for 5 cycles on beat 1 → beat 1 outputs are held unchanged for 5 cycles; total packet takes 8 valid cycles.
- Two packets queued with `ready_i`=1:
  - With `HDR_EMIT_B2B_EN`: 6 consecutive valid cycles, second `rd_o` on the first packet's `eop_o` cycle.
  - Without it: exactly one `valid_o`=0 cycle between the packets.
- Reset asserted during beat 1 → all outputs 0 immediately; after release, no `eop_o` appears for the aborted packet and `pkt_cnt_o`=0.
- Counter wrap: preload via 2^32−1 forced value, emit one packet → `pkt_cnt_o`=0.
- `empty_i`=1 throughout → `rd_o` stays 0 and `valid_o` stays 0 for 100 cycles.
